// File: rtl/riscv_v_pkg.sv
// Shared vector-lane types: multiply opcodes, iterative multiplier FSM states, operand sign helpers.
package riscv_v_pkg;

    typedef enum logic [1:0] {
        OP_MUL    = 2'b00,
        OP_MULH   = 2'b01,
        OP_MULHSU = 2'b10,
        OP_MULHU  = 2'b11
    } mul_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_SIGN = 2'b10,
        ST_DONE = 2'b11
    } vedic_seq_state_e;

    function automatic logic f_mul_op_signed_a(input mul_op_e op);
        return (op == OP_MULH) || (op == OP_MULHSU);
    endfunction

    function automatic logic f_mul_op_signed_b(input mul_op_e op);
        return (op == OP_MULH);
    endfunction

endpackage

// File: rtl/vedic_mul_unsigned.sv
// Combinational unsigned W x W Vedic (Urdhva-Tiryagbhyam) multiplier, built recursively from half-width blocks.
// prev_result_o taps the cross-term sum of the top split level.
module vedic_mul_unsigned #(
    parameter int W = 16
) (
    input  logic [W-1:0]   a_i,
    input  logic [W-1:0]   b_i,
    output logic [2*W-1:0] p_o,
    output logic [2*W-1:0] prev_result_o
);
    import riscv_v_pkg::*;

    generate
        if (W == 1) begin : g_leaf
            assign p_o           = {1'b0, a_i & b_i};
            assign prev_result_o = '0;
        end else begin : g_split
            localparam int Q = W / 2;

            logic [W-1:0] p_ll, p_lh, p_hl, p_hh;
            logic [W:0]   mid;

            vedic_mul_unsigned #(.W(Q)) u_ll (
                .a_i(a_i[Q-1:0]), .b_i(b_i[Q-1:0]), .p_o(p_ll), .prev_result_o());
            vedic_mul_unsigned #(.W(Q)) u_lh (
                .a_i(a_i[Q-1:0]), .b_i(b_i[W-1:Q]), .p_o(p_lh), .prev_result_o());
            vedic_mul_unsigned #(.W(Q)) u_hl (
                .a_i(a_i[W-1:Q]), .b_i(b_i[Q-1:0]), .p_o(p_hl), .prev_result_o());
            vedic_mul_unsigned #(.W(Q)) u_hh (
                .a_i(a_i[W-1:Q]), .b_i(b_i[W-1:Q]), .p_o(p_hh), .prev_result_o());

            // Crosswise terms carry one extra bit before being folded in at weight 2^Q.
            always_comb begin
                mid = {1'b0, p_lh} + {1'b0, p_hl};
            end

            assign p_o           = {p_hh, p_ll} + ({{(W-1){1'b0}}, mid} << Q);
            assign prev_result_o = {{(W-1){1'b0}}, mid};
        end
    endgenerate

endmodule

// File: rtl/vedic_mul_seq.sv
// Iterative signed/unsigned W x W multiplier reusing one half-width Vedic unit over four partial products.
// Latency 6 edges (1 on zero operand); in_ready only in IDLE, result held in DONE until out_ready.
module vedic_mul_seq #(
    parameter int   WIDTH      = 32,
    parameter logic EARLY_ZERO = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic [WIDTH-1:0]   result
);
    import riscv_v_pkg::*;

    localparam int H = WIDTH / 2;
    localparam logic [WIDTH-1:0]   ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [2*WIDTH-1:0] ONE_2W = {{(2*WIDTH-1){1'b0}}, 1'b1};

    vedic_seq_state_e   state_q, state_d;
    mul_op_e            op_q, op_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [1:0]         cnt_q, cnt_d;
    logic [WIDTH-1:0]   ma_q, ma_d, mb_q, mb_d;
    logic               neg_q, neg_d;

    mul_op_e            op_in;
    logic               a_neg, b_neg;
    logic [H-1:0]       pp_a, pp_b;
    logic [WIDTH-1:0]   pp;
    logic [2*WIDTH-1:0] pp_shifted;

    assign op_in = mul_op_e'(op);
    assign a_neg = a[WIDTH-1] & f_mul_op_signed_a(op_in);
    assign b_neg = b[WIDTH-1] & f_mul_op_signed_b(op_in);

    // cnt[1] picks the A half, cnt[0] the B half: ll, lh, hl, hh.
    assign pp_a = cnt_q[1] ? ma_q[WIDTH-1:H] : ma_q[H-1:0];
    assign pp_b = cnt_q[0] ? mb_q[WIDTH-1:H] : mb_q[H-1:0];

    vedic_mul_unsigned #(.W(H)) u_vedic (
        .a_i           (pp_a),
        .b_i           (pp_b),
        .p_o           (pp),
        .prev_result_o ()
    );

    always_comb begin
        pp_shifted = '0;
        case (cnt_q)
            2'd0:       pp_shifted = {{WIDTH{1'b0}}, pp};
            2'd1, 2'd2: pp_shifted = {{WIDTH{1'b0}}, pp} << H;
            default:    pp_shifted = {pp, {WIDTH{1'b0}}};
        endcase
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ma_d    = ma_q;
        mb_d    = mb_q;
        neg_d   = neg_q;
        if (flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        op_d  = op_in;
                        ma_d  = a_neg ? (~a + ONE_W) : a;
                        mb_d  = b_neg ? (~b + ONE_W) : b;
                        neg_d = a_neg ^ b_neg;
                        acc_d = '0;
                        cnt_d = 2'd0;
                        if (EARLY_ZERO && ((a == '0) || (b == '0))) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_MUL;
                        end
                    end
                end
                ST_MUL: begin
                    acc_d = acc_q + pp_shifted;
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d = ST_SIGN;
                    end
                end
                ST_SIGN: begin
                    if (neg_q) begin
                        acc_d = ~acc_q + ONE_2W;
                    end
                    state_d = ST_DONE;
                end
                default: begin
                    if (out_ready) begin
                        state_d = ST_IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            op_q    <= OP_MUL;
            acc_q   <= '0;
            cnt_q   <= 2'd0;
            ma_q    <= '0;
            mb_q    <= '0;
            neg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ma_q    <= ma_d;
            mb_q    <= mb_d;
            neg_q   <= neg_d;
        end
    end

    // The accumulator is only visible in DONE so intermediate sums never leak out.
    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign product   = out_valid ? acc_q : '0;
    assign result    = (op_q == OP_MUL) ? product[WIDTH-1:0] : product[2*WIDTH-1:WIDTH];

endmodule

// File: tb/tb_vedic_mul_seq.sv
// Scoreboard bench for vedic_mul_seq at WIDTH=8, with and without the zero-operand fast path.
module tb_vedic_mul_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0, in_valid1 = 1'b0;
    logic        out_ready = 1'b0, out_ready1 = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [7:0]  a = 8'h00, b = 8'h00;
    logic        in_ready, out_valid, in_ready1, out_valid1;
    logic [15:0] product, product1;
    logic [7:0]  result, result1;

    int checks = 0;
    int errors = 0;
    logic [23:0] sb[$];

    always #5 clk = ~clk;

    vedic_mul_seq #(.WIDTH(8), .EARLY_ZERO(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready), .product(product), .result(result));

    vedic_mul_seq #(.WIDTH(8), .EARLY_ZERO(1'b0)) dut_nz (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid1), .in_ready(in_ready1), .op(op), .a(a), .b(b),
        .out_valid(out_valid1), .out_ready(out_ready1), .product(product1), .result(result1));

    function automatic logic [23:0] model(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y);
        int sx, sy, p;
        logic [15:0] p16;
        sx  = (o == 2'b01 || o == 2'b10) ? int'($signed(x)) : int'(x);
        sy  = (o == 2'b01) ? int'($signed(y)) : int'(y);
        p   = sx * sy;
        p16 = p[15:0];
        return {p16, (o == 2'b00) ? p16[7:0] : p16[15:8]};
    endfunction

    task automatic run_op(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y);
        int lat, exp_lat;
        logic [23:0] e;
        sb.push_back(model(o, x, y));
        exp_lat = (x == 8'h00 || y == 8'h00) ? 1 : 6;
        @(negedge clk);
        op = o; a = x; b = y; in_valid = 1'b1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL ready_before_accept: in_ready=%b want 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        e = sb.pop_front();
        checks++;
        if (lat !== exp_lat) begin
            errors++; $display("FAIL latency op=%0d a=%h b=%h: got %0d want %0d", o, x, y, lat, exp_lat);
        end
        checks++;
        if (product !== e[23:8]) begin
            errors++; $display("FAIL product op=%0d a=%h b=%h: got %h want %h", o, x, y, product, e[23:8]);
        end
        checks++;
        if (result !== e[7:0]) begin
            errors++; $display("FAIL result op=%0d a=%h b=%h: got %h want %h", o, x, y, result, e[7:0]);
        end
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL return_idle: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset;
        #12;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || product !== 16'h0 || result !== 8'h0) begin
            errors++;
            $display("FAIL reset_values: in_ready=%b out_valid=%b product=%h result=%h want 1/0/0000/00",
                     in_ready, out_valid, product, result);
        end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_vectors;
        run_op(2'b11, 8'hFF, 8'hFF);
        run_op(2'b01, 8'h80, 8'h80);
        run_op(2'b00, 8'h80, 8'h80);
        run_op(2'b10, 8'hFF, 8'hFF);
        run_op(2'b01, 8'hFF, 8'h03);
        run_op(2'b10, 8'h80, 8'h80);
        run_op(2'b01, 8'h7F, 8'h81);
    endtask

    task automatic test_random;
        logic [7:0] x, y;
        for (int i = 0; i < 16; i++) begin
            x = $urandom_range(0, 7) == 0 ? 8'h00 : 8'($urandom);
            y = $urandom_range(0, 7) == 0 ? 8'h00 : 8'($urandom);
            run_op(2'($urandom_range(0, 3)), x, y);
        end
    endtask

    task automatic test_early_zero;
        int lat;
        run_op(2'b01, 8'h00, 8'h9C);
        @(negedge clk);
        op = 2'b01; a = 8'h00; b = 8'h9C; in_valid1 = 1'b1;
        @(posedge clk); #1;
        in_valid1 = 1'b0;
        lat = 1;
        while (out_valid1 !== 1'b1 && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        checks++;
        if (lat !== 6) begin
            errors++; $display("FAIL nozero_latency: got %0d want 6", lat);
        end
        checks++;
        if (product1 !== 16'h0000) begin
            errors++; $display("FAIL nozero_product: got %h want 0000", product1);
        end
        @(negedge clk); out_ready1 = 1'b1;
        @(posedge clk); #1; out_ready1 = 1'b0;
        checks++;
        if (in_ready1 !== 1'b1) begin
            errors++; $display("FAIL nozero_idle: in_ready=%b want 1", in_ready1);
        end
    endtask

    task automatic test_backpressure;
        int lat;
        logic [23:0] e;
        sb.push_back(model(2'b01, 8'hC3, 8'h5A));
        @(negedge clk);
        op = 2'b01; a = 8'hC3; b = 8'h5A; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        e = sb.pop_front();
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || product !== e[23:8] || result !== e[7:0]) begin
                errors++;
                $display("FAIL hold_cycle%0d: out_valid=%b in_ready=%b product=%h result=%h want 1/0/%h/%h",
                         i, out_valid, in_ready, product, result, e[23:8], e[7:0]);
            end
        end
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL release_idle: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        op = 2'b11; a = 8'hA5; b = 8'h3C; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || product !== 16'h0 || result !== 8'h0) begin
            errors++;
            $display("FAIL reset_mid_mul: in_ready=%b out_valid=%b product=%h result=%h want 1/0/0000/00",
                     in_ready, out_valid, product, result);
        end
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b0) begin
                errors++; $display("FAIL reset_no_result cycle%0d: out_valid=%b want 0", i, out_valid);
            end
        end
        run_op(2'b11, 8'hA5, 8'h3C);
    endtask

    task automatic test_flush_done;
        int lat;
        @(negedge clk);
        op = 2'b10; a = 8'h91; b = 8'hE7; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        checks++;
        if (out_valid !== 1'b1) begin
            errors++; $display("FAIL flush_reach_done: out_valid=%b want 1", out_valid);
        end
        @(negedge clk); flush = 1'b1;
        @(posedge clk); #1; flush = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL flush_in_done: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
        end
        run_op(2'b01, 8'h85, 8'h7B);
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_early_zero();
        test_random();
        test_backpressure();
        test_reset_mid();
        test_flush_done();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
